// File: rtl/spi_master_ctrl_if.sv
// Request/response and SPI pin bundle for the SPI master controller.
// Latency: none (wires only).
// Backpressure: req_valid/req_ready handshake; rsp_valid is an unconditional one-cycle strobe.
interface spi_master_ctrl_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_rw;
  logic [6:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       busy;
  logic       cs;
  logic       sck;
  logic       mosi;
  logic       miso;

  // Controller view
  modport master (
    input  req_valid, req_rw, req_addr, req_wdata, miso,
    output req_ready, rsp_valid, rsp_rdata, busy, cs, sck, mosi
  );

  // Requester plus SPI slave view
  modport slave (
    output req_valid, req_rw, req_addr, req_wdata, miso,
    input  req_ready, rsp_valid, rsp_rdata, busy, cs, sck, mosi
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// Single-byte SPI read/write sequencer: 16-bit frame {addr, rw, data}, MSB first.
// Latency: accept edge to rsp_valid = 33*CLKDIV cycles; accept-to-accept >= 33*CLKDIV+GAP_CYC+1.
// Backpressure: req_ready only in IDLE; requests offered while busy are ignored, not queued.
module spi_master_ctrl #(
  parameter int CLKDIV  = 4,
  parameter int GAP_CYC = 2
) (
  input  logic              clk,
  input  logic              reset,
  spi_master_ctrl_if.master bus
);

  localparam int DW = (CLKDIV  > 1) ? $clog2(CLKDIV)  : 1;
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLKDIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOW, S_HIGH, S_HOLD, S_GAP} state_t;

  state_t          state_q;
  logic [DW-1:0]   div_q;
  logic [DW-1:0]   div_d;
  logic            div_wrap;
  logic [GW-1:0]   gap_q;
  logic [3:0]      bit_q;
  logic [14:0]     sh_q;     // frame bits still to be sent; [14] is the next bit
  logic [15:0]     frame_d;
  logic            rw_q;
  logic            cs_q;
  logic            sck_q;
  logic            mosi_q;
  logic            rdy_q;
  logic            busy_q;
  logic            rsp_vld_q;
  logic [7:0]      rdata_q;

  // Divider next value and the frame assembled from the live request fields
  always_comb begin
    div_wrap = (div_q == DIV_LAST);
    div_d    = div_wrap ? '0 : div_q + 1'b1;
    frame_d  = {bus.req_addr, bus.req_rw, (bus.req_rw ? 8'h00 : bus.req_wdata)};
  end

  // Transaction FSM; every pin-level output is a register updated here
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      gap_q     <= '0;
      bit_q     <= '0;
      sh_q      <= '0;
      rw_q      <= 1'b0;
      cs_q      <= 1'b1;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
      rdy_q     <= 1'b1;
      busy_q    <= 1'b0;
      rsp_vld_q <= 1'b0;
      rdata_q   <= 8'h00;
    end else begin
      rsp_vld_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid && rdy_q) begin
            rw_q    <= bus.req_rw;
            sh_q    <= frame_d[14:0];
            mosi_q  <= frame_d[15];
            rdata_q <= 8'h00;
            bit_q   <= '0;
            div_q   <= '0;
            cs_q    <= 1'b0;
            sck_q   <= 1'b0;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_LOW;
          end
        end
        S_LOW: begin
          div_q <= div_d;
          if (div_wrap) begin
            // Data phase of a read: sample miso just before sck rises
            if (rw_q && bit_q[3]) begin
              rdata_q <= {rdata_q[6:0], bus.miso};
            end
            sck_q   <= 1'b1;
            state_q <= S_HIGH;
          end
        end
        S_HIGH: begin
          div_q <= div_d;
          if (div_wrap) begin
            sck_q <= 1'b0;
            if (bit_q == 4'd15) begin
              mosi_q  <= 1'b0;
              state_q <= S_HOLD;
            end else begin
              bit_q   <= bit_q + 4'd1;
              mosi_q  <= sh_q[14];
              sh_q    <= {sh_q[13:0], 1'b0};
              state_q <= S_LOW;
            end
          end
        end
        S_HOLD: begin
          div_q <= div_d;
          if (div_wrap) begin
            cs_q      <= 1'b1;
            rsp_vld_q <= 1'b1;
            gap_q     <= '0;
            state_q   <= S_GAP;
          end
        end
        S_GAP: begin
          if (gap_q == GAP_LAST) begin
            rdy_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready = rdy_q;
  assign bus.rsp_valid = rsp_vld_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.busy      = busy_q;
  assign bus.cs        = cs_q;
  assign bus.sck       = sck_q;
  assign bus.mosi      = mosi_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: two instances (CLKDIV=4/GAP=2 and CLKDIV=1/GAP=1)
// sharing one behavioural SPI memory slave, selected by sel.
// Expected read data is queued at request time and popped on rsp_valid.
module tb_spi_master_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spi_master_ctrl_if ifa ();
  spi_master_ctrl_if ifb ();

  spi_master_ctrl #(.CLKDIV(4), .GAP_CYC(2)) dut_a (.clk(clk), .reset(reset), .bus(ifa.master));
  spi_master_ctrl #(.CLKDIV(1), .GAP_CYC(1)) dut_b (.clk(clk), .reset(reset), .bus(ifb.master));

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q [$];
  logic sel = 1'b0;

  // ---------------- behavioural SPI memory slave ----------------
  logic [7:0] mem [128];
  logic s_cs, s_sck, s_mosi;
  logic s_miso = 1'b0;
  int   sl_cnt = 0;
  logic [15:0] sl_sh = '0;
  logic sl_rd = 1'b0;
  logic [7:0] sl_out = '0;
  int   rises = 0;
  logic [15:0] cap = '0;

  assign s_cs     = sel ? ifb.cs   : ifa.cs;
  assign s_sck    = sel ? ifb.sck  : ifa.sck;
  assign s_mosi   = sel ? ifb.mosi : ifa.mosi;
  assign ifa.miso = s_miso;
  assign ifb.miso = s_miso;

  initial for (int i = 0; i < 128; i++) mem[i] = 8'h00;

  always @(posedge s_sck or posedge s_cs) begin
    if (s_cs) begin
      sl_cnt = 0;
      sl_rd  = 1'b0;
    end else begin
      sl_sh = {sl_sh[14:0], s_mosi};
      sl_cnt++;
      if (sl_cnt == 8) begin
        sl_rd  = s_mosi;
        sl_out = mem[sl_sh[7:1]];
      end
      if (sl_cnt == 16 && !sl_rd) mem[sl_sh[15:9]] = sl_sh[7:0];
    end
  end

  always @(negedge s_sck) begin
    if (!s_cs && sl_rd && sl_cnt >= 8 && sl_cnt < 16) begin
      s_miso = sl_out[7];
      sl_out = {sl_out[6:0], 1'b0};
    end
  end

  always @(posedge s_sck) begin
    rises++;
    cap = {cap[14:0], s_mosi};
  end

  // ---------------- protocol checker ----------------
  bit   chk_en = 1'b0;
  int   chk_bad = 0;
  logic pa_mosi, pa_cs, pb_mosi, pb_cs;

  always @(negedge clk) begin
    if (chk_en) begin
      if (ifa.sck && ifa.mosi !== pa_mosi) chk_bad++;
      if (ifa.sck && ifa.cs && !pa_cs)     chk_bad++;
      if (ifa.busy && ifa.req_ready)       chk_bad++;
      if (ifb.sck && ifb.mosi !== pb_mosi) chk_bad++;
      if (ifb.sck && ifb.cs && !pb_cs)     chk_bad++;
      if (ifb.busy && ifb.req_ready)       chk_bad++;
    end
    pa_mosi = ifa.mosi; pa_cs = ifa.cs;
    pb_mosi = ifb.mosi; pb_cs = ifb.cs;
  end

  // ---------------- helpers ----------------
  function automatic logic f_rdy();
    return sel ? ifb.req_ready : ifa.req_ready;
  endfunction
  function automatic logic f_rv();
    return sel ? ifb.rsp_valid : ifa.rsp_valid;
  endfunction
  function automatic logic f_sck();
    return sel ? ifb.sck : ifa.sck;
  endfunction
  function automatic logic [7:0] f_rdata();
    return sel ? ifb.rsp_rdata : ifa.rsp_rdata;
  endfunction

  task automatic drive(input logic v, input logic rw, input logic [6:0] a, input logic [7:0] wd);
    if (sel) begin
      ifb.req_valid = v; ifb.req_rw = rw; ifb.req_addr = a; ifb.req_wdata = wd;
    end else begin
      ifa.req_valid = v; ifa.req_rw = rw; ifa.req_addr = a; ifa.req_wdata = wd;
    end
  endtask

  // One complete transaction with latency, sck and response checks
  task automatic do_txn(input logic s, input logic rw, input logic [6:0] a,
                        input logic [7:0] wd, input logic [7:0] exp_rd, input string nm);
    int n, lat, tog, r0;
    logic psck;
    logic [7:0] got, want;
    @(negedge clk);
    sel = s;
    exp_q.push_back(exp_rd);
    drive(1'b1, rw, a, wd);
    n = 0;
    while (f_rdy() !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    total++;
    if (n >= 2000) begin
      bad++;
      $display("FAIL %s_accept: req_ready not seen within 2000 cycles", nm);
      drive(1'b0, 1'b0, 7'h00, 8'h00);
      void'(exp_q.pop_back());
      return;
    end
    r0 = rises;
    @(negedge clk);
    drive(1'b0, 1'b0, 7'h00, 8'h00);
    lat = 0; tog = 0; psck = f_sck();
    while (f_rv() !== 1'b1 && lat < 2000) begin
      @(negedge clk);
      lat++;
      if (f_sck() !== psck) tog++;
      psck = f_sck();
    end
    want = exp_q.pop_front();
    got  = f_rdata();
    total++;
    if (got !== want) begin bad++; $display("FAIL %s_rdata: got %h want %h", nm, got, want); end
    total++;
    if (lat !== (s ? 33 : 132)) begin bad++; $display("FAIL %s_latency: got %0d want %0d", nm, lat, (s ? 33 : 132)); end
    total++;
    if (rises - r0 !== 16) begin bad++; $display("FAIL %s_sck_rises: got %0d want 16", nm, rises - r0); end
    total++;
    if (tog !== 32) begin bad++; $display("FAIL %s_sck_toggles: got %0d want 32", nm, tog); end
    @(negedge clk);
    total++;
    if (f_rv() !== 1'b0) begin bad++; $display("FAIL %s_rsp_pulse: rsp_valid %b want 0", nm, f_rv()); end
    total++;
    if (f_rdata() !== want) begin bad++; $display("FAIL %s_rdata_hold: got %h want %h", nm, f_rdata(), want); end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++; if (ifa.cs !== 1'b1)         begin bad++; $display("FAIL rst_cs: got %b want 1", ifa.cs); end
    total++; if (ifa.sck !== 1'b0)        begin bad++; $display("FAIL rst_sck: got %b want 0", ifa.sck); end
    total++; if (ifa.mosi !== 1'b0)       begin bad++; $display("FAIL rst_mosi: got %b want 0", ifa.mosi); end
    total++; if (ifa.req_ready !== 1'b1)  begin bad++; $display("FAIL rst_ready: got %b want 1", ifa.req_ready); end
    total++; if (ifa.rsp_valid !== 1'b0)  begin bad++; $display("FAIL rst_rsp_valid: got %b want 0", ifa.rsp_valid); end
    total++; if (ifa.rsp_rdata !== 8'h00) begin bad++; $display("FAIL rst_rdata: got %h want 00", ifa.rsp_rdata); end
    total++; if (ifa.busy !== 1'b0)       begin bad++; $display("FAIL rst_busy: got %b want 0", ifa.busy); end
    total++; if (ifb.req_ready !== 1'b1 || ifb.cs !== 1'b1)
      begin bad++; $display("FAIL rst_b: ready %b cs %b want 1 1", ifb.req_ready, ifb.cs); end
  endtask

  task automatic test_read_basic();
    do_txn(1'b0, 1'b1, 7'h2A, 8'h00, 8'h00, "read_2a_init");
  endtask

  task automatic test_write_read();
    do_txn(1'b0, 1'b0, 7'h2A, 8'h33, 8'h00, "write_2a");
    total++;
    if (cap !== 16'b0101010_0_00110011) begin bad++; $display("FAIL mosi_frame: got %b want 0101010000110011", cap); end
    do_txn(1'b0, 1'b1, 7'h2A, 8'h00, 8'h33, "read_2a");
    repeat (5) @(negedge clk);
    total++;
    if (ifa.rsp_rdata !== 8'h33) begin bad++; $display("FAIL rdata_idle_hold: got %h want 33", ifa.rsp_rdata); end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [7:0] want;
    @(negedge clk);
    sel = 1'b0;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hA5);
    drive(1'b1, 1'b0, 7'h05, 8'hA5);
    n = 0;
    while (ifa.req_ready !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    @(negedge clk);
    drive(1'b1, 1'b1, 7'h05, 8'h00);
    n = 0;
    while (ifa.rsp_valid !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    want = exp_q.pop_front();
    total++;
    if (ifa.rsp_valid !== 1'b1 || ifa.rsp_rdata !== want)
      begin bad++; $display("FAIL b2b_first: rsp_valid %b rdata %h want 1 %h", ifa.rsp_valid, ifa.rsp_rdata, want); end
    n = 0;
    while (ifa.req_ready !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    total++;
    if (n + 1 !== 3) begin bad++; $display("FAIL b2b_gap: accept %0d cycles after rsp_valid want 3", n + 1); end
    @(negedge clk);
    drive(1'b0, 1'b0, 7'h00, 8'h00);
    n = 0;
    while (ifa.rsp_valid !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    want = exp_q.pop_front();
    total++;
    if (ifa.rsp_valid !== 1'b1 || ifa.rsp_rdata !== want)
      begin bad++; $display("FAIL b2b_read: rsp_valid %b rdata %h want 1 %h", ifa.rsp_valid, ifa.rsp_rdata, want); end
  endtask

  task automatic test_reset_abort();
    int n, r0;
    bit seen;
    @(negedge clk);
    sel = 1'b0;
    drive(1'b1, 1'b0, 7'h05, 8'h3C);
    n = 0;
    while (ifa.req_ready !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    r0 = rises;
    @(negedge clk);
    drive(1'b0, 1'b0, 7'h00, 8'h00);
    n = 0;
    while (rises - r0 < 8 && n < 2000) begin @(negedge clk); n++; end
    total++;
    if (rises - r0 !== 8) begin bad++; $display("FAIL abort_8th_edge: saw %0d rises want 8", rises - r0); end
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (ifa.cs !== 1'b1 || ifa.sck !== 1'b0 || ifa.busy !== 1'b0 || ifa.rsp_valid !== 1'b0)
      begin bad++; $display("FAIL abort_outputs: cs %b sck %b busy %b rv %b want 1 0 0 0",
                            ifa.cs, ifa.sck, ifa.busy, ifa.rsp_valid); end
    reset = 1'b0;
    seen = 1'b0;
    repeat (20) begin @(negedge clk); if (ifa.rsp_valid === 1'b1) seen = 1'b1; end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL abort_no_rsp: rsp_valid seen %b want 0", seen); end
    do_txn(1'b0, 1'b1, 7'h05, 8'h00, 8'hA5, "reread_05");
  endtask

  task automatic test_fast();
    do_txn(1'b1, 1'b0, 7'h7F, 8'hFF, 8'h00, "fast_write_7f");
    do_txn(1'b1, 1'b1, 7'h7F, 8'h00, 8'hFF, "fast_read_7f");
  endtask

  task automatic test_checker();
    total++;
    if (chk_bad !== 0) begin bad++; $display("FAIL protocol_checker: %0d violations want 0", chk_bad); end
  endtask

  initial begin
    reset = 1'b1;
    ifa.req_valid = 1'b0; ifa.req_rw = 1'b0; ifa.req_addr = '0; ifa.req_wdata = '0;
    ifb.req_valid = 1'b0; ifb.req_rw = 1'b0; ifb.req_addr = '0; ifb.req_wdata = '0;
    test_reset();
    chk_en = 1'b1;
    test_read_basic();
    test_write_read();
    test_back_to_back();
    test_reset_abort();
    test_fast();
    repeat (5) @(negedge clk);
    test_checker();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
